// File: rtl/conv_img_streamer.sv
// -----------------------------------------------------------------------------
// conv_img_streamer
//
// Output-side companion to the convolution core. The core presents its whole
// result as one flat ROWS x COLS x PIX_W bus and pulses done. This block
// captures that bus into a shadow register on a load strobe (tie load to done).
// It then streams the pixels out one per valid/ready handshake in row-major
// order, with row/column indices and start-of-frame, end-of-line and
// end-of-frame markers, for downstream display and memory logic.
//
// Pixel (r,c) sits at img_in[(r*COLS+c)*PIX_W +: PIX_W].
//
// Ports
//   clk         in   1            rising-edge clock
//   rst         in   1            synchronous reset, active-low
//   load        in   1            capture strobe for img_in
//   img_in      in   IMG_W        flat image bus
//   busy        out  1            high while a frame is being streamed
//   pix_valid   out  1            pix_data and markers are valid
//   pix_ready   in   1            downstream accepts the beat when high
//   pix_data    out  PIX_W        current pixel, 0 when pix_valid=0
//   pix_row     out  RW           row index of current pixel
//   pix_col     out  CW           column index of current pixel
//   sof         out  1            first pixel of the frame
//   eol         out  1            last pixel of a row
//   eof         out  1            last pixel of the frame
//   frame_done  out  1            pulse, cycle after the final beat transfers
//   overrun     out  1            pulse, cycle after a rejected load
// -----------------------------------------------------------------------------
module conv_img_streamer #(
  parameter  int ROWS  = 9,
  parameter  int COLS  = 9,
  parameter  int PIX_W = 8,
  localparam int IMG_W = ROWS * COLS * PIX_W,
  localparam int RW    = $clog2(ROWS),
  localparam int CW    = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IMG_W-1:0] img_in,
  output logic             busy,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data,
  output logic [RW-1:0]    pix_row,
  output logic [CW-1:0]    pix_col,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic             frame_done,
  output logic             overrun
);

  localparam int NPIX = ROWS * COLS;
  localparam int IW   = $clog2(NPIX);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [IMG_W-1:0]   shadow_q, shadow_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;

  logic               valid;
  logic               last_pos;
  logic               col_last;
  logic               beat;
  logic               final_beat;
  logic               load_ok;
  logic               load_take;
  logic [IW-1:0]      pix_idx;
  logic [PIX_W-1:0]   pix_arr [NPIX];

  // View the shadow register as an array of pixels so the output mux is a
  // plain indexed read by linear position.
  generate
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_unpack
      assign pix_arr[gi] = shadow_q[gi*PIX_W +: PIX_W];
    end
  endgenerate

  assign valid      = (state_q == STREAM);
  assign col_last   = (col_q == CW'(COLS - 1));
  assign last_pos   = (row_q == RW'(ROWS - 1)) && col_last;
  assign beat       = valid && pix_ready;
  assign final_beat = beat && last_pos;

  // A new image may only replace the shadow when nothing is in flight, or in
  // the very cycle the last pixel leaves; this gives gap-free back-to-back
  // frames without ever corrupting a frame mid-stream.
  assign load_ok    = !valid || final_beat;
  assign load_take  = load && load_ok;

  assign pix_idx    = IW'(row_q) * IW'(COLS) + IW'(col_q);

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    shadow_d     = shadow_q;
    frame_done_d = final_beat;
    overrun_d    = load && !load_ok;

    if (load_take) begin
      shadow_d = img_in;
      row_d    = '0;
      col_d    = '0;
      state_d  = STREAM;
    end else if (beat) begin
      if (last_pos) begin
        // Counters return to the origin so idle outputs read as zero.
        row_d   = '0;
        col_d   = '0;
        state_d = IDLE;
      end else if (col_last) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      shadow_q     <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      shadow_q     <= shadow_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Everything below decodes registered state only, so data and markers stay
  // stable while the downstream stalls.
  assign busy       = valid;
  assign pix_valid  = valid;
  assign pix_data   = valid ? pix_arr[pix_idx] : '0;
  assign pix_row    = row_q;
  assign pix_col    = col_q;
  assign sof        = valid && (row_q == '0) && (col_q == '0);
  assign eol        = valid && col_last;
  assign eof        = valid && last_pos;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_conv_img_streamer.sv
module tb_conv_img_streamer;

  localparam int ROWS  = 9;
  localparam int COLS  = 9;
  localparam int PIX_W = 8;
  localparam int NPIX  = ROWS * COLS;
  localparam int IMG_W = NPIX * PIX_W;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic [IMG_W-1:0] img_in = '0;
  logic             pix_ready = 1'b0;
  logic             busy, pix_valid, sof, eol, eof, frame_done, overrun;
  logic [PIX_W-1:0] pix_data;
  logic [RW-1:0]    pix_row;
  logic [CW-1:0]    pix_col;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the image the current frame must carry, and a staging
  // image for the next load.
  logic [PIX_W-1:0] exp_img [NPIX];
  logic [PIX_W-1:0] stage   [NPIX];

  conv_img_streamer #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .load(load), .img_in(img_in),
    .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
    .sof(sof), .eol(eol), .eof(eof),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need $finish");
    $fatal(1);
  end

  function automatic logic [IMG_W-1:0] pack_stage();
    logic [IMG_W-1:0] b;
    b = '0;
    for (int i = 0; i < NPIX; i++) b[i*PIX_W +: PIX_W] = stage[i];
    return b;
  endfunction

  // All outputs packed in one word for idle comparisons.
  function automatic logic [22:0] out_word();
    return {pix_valid, busy, sof, eol, eof, overrun, frame_done, pix_data, pix_row, pix_col};
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) stage[r*COLS+c] = 8'(3*r + c + 3);
  endtask

  task automatic fill_diag();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) stage[r*COLS+c] = 8'(r + c);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NPIX; i++) stage[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic load_frame();
    @(negedge clk);
    img_in = pack_stage();
    load   = 1'b1;
    for (int i = 0; i < NPIX; i++) exp_img[i] = stage[i];
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Walks one frame from beat 0, comparing every cycle against the model.
  task automatic stream_frame(input string tag, input logic fd_first,
                              input int stall_at, input int stall_len,
                              input int ovr_at, input bit b2b, input bit rnd,
                              output int cycles);
    int   k;
    int   r;
    int   c;
    int   stall_rem;
    logic ovr_exp;
    bit   ovr_done;
    k = 0; stall_rem = stall_len; ovr_exp = 1'b0; ovr_done = 0; cycles = 0;
    while (k < NPIX) begin
      r = k / COLS;
      c = k % COLS;
      n_vec++;
      if ({pix_valid, busy} !== 2'b11 || pix_data !== exp_img[k] ||
          pix_row !== RW'(r) || pix_col !== CW'(c)) begin
        n_err++;
        $display("FAIL %s_pixel beat %0d: got valid=%b busy=%b data=%0d row=%0d col=%0d, need valid=1 busy=1 data=%0d row=%0d col=%0d",
                 tag, k, pix_valid, busy, pix_data, pix_row, pix_col, exp_img[k], r, c);
      end
      n_vec++;
      if (sof !== (k == 0) || eol !== (c == COLS-1) || eof !== (k == NPIX-1)) begin
        n_err++;
        $display("FAIL %s_markers beat %0d: got sof=%b eol=%b eof=%b, need sof=%b eol=%b eof=%b",
                 tag, k, sof, eol, eof, k == 0, c == COLS-1, k == NPIX-1);
      end
      n_vec++;
      if (frame_done !== ((cycles == 0) ? fd_first : 1'b0) || overrun !== ovr_exp) begin
        n_err++;
        $display("FAIL %s_pulses beat %0d: got frame_done=%b overrun=%b, need frame_done=%b overrun=%b",
                 tag, k, frame_done, overrun, (cycles == 0) ? fd_first : 1'b0, ovr_exp);
      end
      load    = 1'b0;
      ovr_exp = 1'b0;
      if (k == stall_at && stall_rem > 0) begin
        pix_ready = 1'b0;
        stall_rem--;
      end else if (rnd && k != NPIX-1) begin
        pix_ready = ($urandom_range(0, 3) != 0);
      end else begin
        pix_ready = 1'b1;
      end
      if (k == ovr_at && !ovr_done) begin
        img_in   = '1;
        load     = 1'b1;
        ovr_exp  = 1'b1;
        ovr_done = 1;
      end
      if (b2b && k == NPIX-1) begin
        img_in = pack_stage();
        load   = 1'b1;
      end
      if (pix_ready) k++;
      cycles++;
      @(negedge clk);
      if (cycles > 4000) begin
        n_err++;
        $display("FAIL %s_timeout: got %0d beats after %0d cycles, need %0d", tag, k, cycles, NPIX);
        break;
      end
    end
    load = 1'b0;
    if (b2b) for (int i = 0; i < NPIX; i++) exp_img[i] = stage[i];
  endtask

  task automatic check_frame_end(input string tag);
    n_vec++;
    if (out_word() !== {6'b0, 1'b1, 16'h0}) begin
      n_err++;
      $display("FAIL %s_end: got outputs=%h, need %h", tag, out_word(), {6'b0, 1'b1, 16'h0});
    end
    @(negedge clk);
    n_vec++;
    if (out_word() !== 23'h0) begin
      n_err++;
      $display("FAIL %s_idle: got outputs=%h, need 0", tag, out_word());
    end
  endtask

  task automatic test_reset();
    fill_ramp();
    img_in = pack_stage();
    load   = 1'b1;
    rst    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_word() !== 23'h0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: got %h, need 0", i, out_word());
      end
    end
    rst  = 1'b1;
    load = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_word() !== 23'h0) begin
      n_err++;
      $display("FAIL reset_load_ignored: got %h, need 0", out_word());
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_frame();
    int cyc;
    fill_ramp();
    load_frame();
    stream_frame("basic", 1'b0, -1, 0, -1, 0, 0, cyc);
    n_vec++;
    if (cyc !== NPIX) begin
      n_err++;
      $display("FAIL basic_busy_cycles: got %0d, need %0d", cyc, NPIX);
    end
    check_frame_end("basic");
    $display("test_basic_frame done, %0d cycles", cyc);
  endtask

  task automatic test_backpressure();
    int cyc;
    fill_ramp();
    load_frame();
    stream_frame("stall", 1'b0, 10, 5, -1, 0, 0, cyc);
    n_vec++;
    if (cyc !== NPIX + 5) begin
      n_err++;
      $display("FAIL stall_cycles: got %0d, need %0d", cyc, NPIX + 5);
    end
    check_frame_end("stall");
    $display("test_backpressure done, %0d cycles", cyc);
  endtask

  task automatic test_busy_load();
    int cyc;
    fill_ramp();
    load_frame();
    stream_frame("overrun", 1'b0, -1, 0, 40, 0, 0, cyc);
    check_frame_end("overrun");
    $display("test_busy_load done, %0d cycles", cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    fill_ramp();
    load_frame();
    fill_diag();
    stream_frame("b2b_first", 1'b0, -1, 0, -1, 1, 0, cyc);
    n_vec++;
    if ({pix_valid, sof, frame_done, pix_data} !== {3'b111, 8'h00}) begin
      n_err++;
      $display("FAIL b2b_handover: got valid=%b sof=%b frame_done=%b data=%0d, need 1 1 1 0",
               pix_valid, sof, frame_done, pix_data);
    end
    stream_frame("b2b_second", 1'b1, -1, 0, -1, 0, 0, cyc);
    check_frame_end("b2b");
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    fill_ramp();
    load_frame();
    pix_ready = 1'b1;
    repeat (30) @(negedge clk);
    n_vec++;
    if (pix_row !== RW'(3) || pix_col !== CW'(3) || pix_data !== 8'd15) begin
      n_err++;
      $display("FAIL midreset_pos: got row=%0d col=%0d data=%0d, need 3 3 15", pix_row, pix_col, pix_data);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_vec++;
    if (out_word() !== 23'h0) begin
      n_err++;
      $display("FAIL midreset_cleared: got %h, need 0", out_word());
    end
    @(negedge clk);
    n_vec++;
    if (out_word() !== 23'h0) begin
      n_err++;
      $display("FAIL midreset_no_done: got %h, need 0", out_word());
    end
    load_frame();
    stream_frame("restart", 1'b0, -1, 0, -1, 0, 0, cyc);
    check_frame_end("restart");
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_random();
    int cyc;
    for (int t = 0; t < 3; t++) begin
      fill_rand();
      load_frame();
      stream_frame("random", 1'b0, -1, 0, int'($urandom_range(0, NPIX-2)), 0, 1, cyc);
      check_frame_end("random");
      $display("test_random frame %0d done, %0d cycles", t, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_busy_load();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
